multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Parametrised successor to the multicycle control decode: integrates the state sequencer with the control decode.
//  Adds memory wait-state handshake, a HALT state, an opcode latch and a retired-instruction counter.
//  Sits between the instruction register/memory and the datapath muxes and write enables of the multicycle CPU.
// PARAMETERS
//  OPW     6  opcode width (>=4); class = opcode[OPW-1:OPW-2]
//  ALUW    4  ALU op width (>=4); ALU/RI op = opcode[ALUW-1:0] zero-extended if OPW<ALUW
//  CNT_W  16  retired-instruction counter width
//  ALU_ADD 0  ALUW-bit ALU add code, used in FETCH, DECODE and MEM3
// PORTS
//  clk                 in   1     clock; all state updates on rising edge
//  rst_n               in   1     synchronous active-low reset
//  opcode              in   OPW   opcode field from IR; sampled at end of DECODE
//  mem_ready           in   1     memory completes current access this cycle
//  state               out  4     current state encoding (debug)
//  pc_write            out  1     unconditional PC write
//  pc_write_cond       out  1     PC write if ALU zero
//  mem_get_data        out  1     1 = instruction address (PC), 0 = data address
//  mem_read            out  1     1 = read, 0 = write
//  reg_write_data_sel  out  2     0 MDR, 1 ALUOUT, 2 sign-extended big immediate
//  ir_write            out  1     IR load enable
//  reg_write           out  1     register-file write enable
//  alu_src_a           out  1     0 PC, 1 busA
//  alu_src_b           out  2     0 const 4, 1 busB, 2 SE<<offset, 3 SE offset
//  alu_op              out  ALUW  ALU operation
//  pc_src              out  2     0 ALUOUT, 1 jump address, 2 ALU direct
//  halted              out  1     core stopped in HALT
//  retired             out  CNT_W instructions completed, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-low.
//  - rst_n=0 at an edge: state<=FETCH, retired<=0, opcode latch<=0.
//  - Reset aborts any state, including a pending wait.
//  - While rst_n=0, all write enables (pc_write, pc_write_cond, ir_write, reg_write) are forced to 0 and mem_read is forced to 1.
//  Outputs: combinational (Moore) from the state register and the opcode latch. Don't-care fields drive 0.
//  Opcode classes, using latched opcode op:
//  - 00: R-type ALU.
//  - 01: RI-type ALU.
//  - 10: memory group. op[1]=1 is load-immediate; otherwise op[0]=0 is load, op[0]=1 is store.
//  - 11: control group. All-ones is HALT; op[3]=1 is jump; op[3]=0 is branch.
//  States, transitions and active outputs (outputs not listed are 0, except mem_read, which is 1 unless listed):
//  - FETCH: mem_get_data=1, ir_write=1, pc_write=1, src_a=PC, src_b=4, ALU_ADD, pc_src=2.
//    - ir_write and pc_write are asserted only when mem_ready=1.
//    - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
//  - DECODE: src_a=PC, src_b=2, ALU_ADD. Latch opcode, then dispatch by class to IMM2, ALU_R3, ALU_RI3, MEM3, BR3, JUMP3 or HALT.
//  - ALU_R3: src_a=busA, src_b=busB, alu_op=op; go to ALU4.
//  - ALU_RI3: as ALU_R3 but src_b=3; go to ALU4.
//  - ALU4: sel=ALUOUT, reg_write=1; go to FETCH.
//  - IMM2: sel=2, reg_write=1; go to FETCH.
//  - BR3: pc_write_cond=1, src_a=busA, src_b=busB, alu_op={1,op[2:0]} zero-padded to ALUW; go to FETCH.
//  - JUMP3: pc_write=1, pc_src=1; go to FETCH.
//  - MEM3: src_a=busA, src_b=3, ALU_ADD; go to LOAD4 or STORE4.
//  - LOAD4: waits on mem_ready, then goes to LOAD5.
//  - STORE4: mem_read=0 held for every wait cycle; go to FETCH on mem_ready=1.
//  - LOAD5: sel=MDR, reg_write=1; go to FETCH.
//  - HALT: halted=1, all enables 0. Terminal until reset.
//  Retired counter: increments by 1 on every transition into FETCH (from IMM2, ALU4, BR3, JUMP3, STORE4 or LOAD5); wraps to 0 after all-ones.
//  Latency with zero wait: R/RI/branch/jump/load-imm 4 or 3 cycles, store 4, load 5.
//  - Each cycle mem_ready=0 in a wait state adds one cycle.
//  mem_ready is ignored outside FETCH, LOAD4 and STORE4.
//  Unused state encodes go to FETCH on the next edge with all enables 0.
// TESTING
//  - Reset, then R-type op=6'b000011 with mem_ready=1 -> FETCH, DECODE, ALU_R3 (alu_op=4'b0011), ALU4 (reg_write=1); retired=1.
//  - Load op=6'b100000, mem_ready low 3 cycles in LOAD4 -> LOAD4 held 4 cycles, then LOAD5 with sel=0; total 8 cycles.
//  - Store op=6'b100001, mem_ready low 2 cycles -> mem_read=0 on all 3 STORE4 cycles, then FETCH.
//  - Branch op=6'b110101 -> BR3 with pc_write_cond=1, alu_op=4'b1101; jump op=6'b111000 -> JUMP3 with pc_src=1, pc_write=1.
//  - HALT op=6'b111111 -> halted=1 and enables 0 for 20 cycles; rst_n=0 for 1 edge -> FETCH, retired=0.
//  - CNT_W=2: 5 RI ops -> retired sequence 1,2,3,0,1.
//  - rst_n=0 mid-LOAD4 -> FETCH, no reg_write.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Control sequencer and decode for the multicycle CPU: state machine, opcode latch,
// memory wait-state handshake, HALT state and retired-instruction counter.
module multicycle_control_fsm #(
    parameter int               OPW     = 6,
    parameter int               ALUW    = 4,
    parameter int               CNT_W   = 16,
    parameter logic [ALUW-1:0]  ALU_ADD = {ALUW{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   opcode,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             mem_get_data,
    output logic             mem_read,
    output logic [1:0]       reg_write_data_sel,
    output logic             ir_write,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [ALUW-1:0]  alu_op,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_IMM2    = 4'd2,
        S_ALU_R3  = 4'd3,
        S_ALU_RI3 = 4'd4,
        S_ALU4    = 4'd5,
        S_BR3     = 4'd6,
        S_JUMP3   = 4'd7,
        S_MEM3    = 4'd8,
        S_LOAD4   = 4'd9,
        S_STORE4  = 4'd10,
        S_LOAD5   = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    state_t           state_r;
    logic [OPW-1:0]   op_r;
    logic [CNT_W-1:0] retired_r;

    logic             pc_write_s;
    logic             pc_write_cond_s;
    logic             ir_write_s;
    logic             reg_write_s;
    logic             mem_read_s;

    // Class lives in the top two opcode bits; the control group splits on all-ones and bit 3.
    function automatic state_t dispatch(input logic [OPW-1:0] op);
        state_t nxt;
        case (op[OPW-1:OPW-2])
            2'b00:   nxt = S_ALU_R3;
            2'b01:   nxt = S_ALU_RI3;
            2'b10:   nxt = op[1] ? S_IMM2 : S_MEM3;
            2'b11:   nxt = (&op) ? S_HALT : (op[3] ? S_JUMP3 : S_BR3);
            default: nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

    // State sequencing, opcode latch and retired counter (bumped on each return to FETCH).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            op_r      <= {OPW{1'b0}};
            retired_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_FETCH:   if (mem_ready) state_r <= S_DECODE;
                S_DECODE: begin
                    op_r    <= opcode;
                    state_r <= dispatch(opcode);
                end
                S_ALU_R3,
                S_ALU_RI3: state_r <= S_ALU4;
                S_ALU4, S_IMM2, S_BR3, S_JUMP3, S_LOAD5: begin
                    state_r   <= S_FETCH;
                    retired_r <= retired_r + CNT_W'(1'b1);
                end
                S_MEM3:    state_r <= op_r[0] ? S_STORE4 : S_LOAD4;
                S_LOAD4:   if (mem_ready) state_r <= S_LOAD5;
                S_STORE4: begin
                    if (mem_ready) begin
                        state_r   <= S_FETCH;
                        retired_r <= retired_r + CNT_W'(1'b1);
                    end
                end
                S_HALT:    state_r <= S_HALT;
                default:   state_r <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the datapath controls; unused fields and unused encodes drive 0.
    always_comb begin
        pc_write_s         = 1'b0;
        pc_write_cond_s    = 1'b0;
        mem_get_data       = 1'b0;
        mem_read_s         = 1'b1;
        reg_write_data_sel = 2'd0;
        ir_write_s         = 1'b0;
        reg_write_s        = 1'b0;
        alu_src_a          = 1'b0;
        alu_src_b          = 2'd0;
        alu_op             = {ALUW{1'b0}};
        pc_src             = 2'd0;
        halted             = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_get_data = 1'b1;
                ir_write_s   = mem_ready;
                pc_write_s   = mem_ready;
                alu_op       = ALU_ADD;
                pc_src       = 2'd2;
            end
            S_DECODE: begin
                alu_src_b = 2'd2;
                alu_op    = ALU_ADD;
            end
            S_ALU_R3: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = ALUW'(op_r);
            end
            S_ALU_RI3: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd3;
                alu_op    = ALUW'(op_r);
            end
            S_ALU4: begin
                reg_write_data_sel = 2'd1;
                reg_write_s        = 1'b1;
            end
            S_IMM2: begin
                reg_write_data_sel = 2'd2;
                reg_write_s        = 1'b1;
            end
            S_BR3: begin
                pc_write_cond_s = 1'b1;
                alu_src_a       = 1'b1;
                alu_src_b       = 2'd1;
                alu_op          = ALUW'({1'b1, op_r[2:0]});
            end
            S_JUMP3: begin
                pc_write_s = 1'b1;
                pc_src     = 2'd1;
            end
            S_MEM3: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd3;
                alu_op    = ALU_ADD;
            end
            S_LOAD4:  mem_read_s = 1'b1;
            S_STORE4: mem_read_s = 1'b0;
            S_LOAD5: begin
                reg_write_data_sel = 2'd0;
                reg_write_s        = 1'b1;
            end
            S_HALT:   halted = 1'b1;
            default:  mem_read_s = 1'b1;
        endcase
    end

    // Reset overrides every write enable and parks memory in read mode.
    assign pc_write      = rst_n & pc_write_s;
    assign pc_write_cond = rst_n & pc_write_cond_s;
    assign ir_write      = rst_n & ir_write_s;
    assign reg_write     = rst_n & reg_write_s;
    assign mem_read      = ~rst_n | mem_read_s;
    assign state         = state_r;
    assign retired       = retired_r;

endmodule
